// File: rtl/fc_output_layer.sv
// LeNet-5 output layer: buffers one feature vector, then runs a serial
// MAC per class neuron against an external weight/bias ROM.
module fc_output_layer #(
    parameter int DATA_SIZE = 8,
    parameter int N_IN      = 84,
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 7,
    parameter int W_ADDR_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fc_start,
    input  logic                      in_vld,
    input  logic [DATA_SIZE-1:0]      in_data,
    output logic                      in_rdy,
    output logic                      w_rd,
    output logic [W_ADDR_W-1:0]       w_addr,
    input  logic [DATA_SIZE-1:0]      w_data,
    output logic                      fc_busy,
    output logic [10*DATA_SIZE-1:0]   fc_result,
    output logic                      classify_en
);

    localparam int CW = $clog2(N_IN + 2);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW = 2 * DATA_SIZE + 1;

    localparam logic [CW-1:0] K_LAST = CW'(N_IN - 1);
    localparam logic [CW-1:0] K_BIAS = CW'(N_IN);
    localparam logic [CW-1:0] K_WB   = CW'(N_IN + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        DONE
    } state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [3:0]               nrn;
    logic [DATA_SIZE-1:0]     fbuf [N_IN];
    logic [DATA_SIZE-1:0]     feat_q;
    logic signed [ACC_W-1:0]  acc;

    logic signed [PW-1:0]     feat_x;
    logic signed [PW-1:0]     wgt_x;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  total;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_SIZE-1:0]     score;

    // feat_q is registered alongside the ROM read so it lines up with w_data
    assign feat_x   = {{(PW-DATA_SIZE){1'b0}}, feat_q};
    assign wgt_x    = {{(PW-DATA_SIZE){w_data[DATA_SIZE-1]}}, w_data};
    assign prod     = feat_x * wgt_x;
    assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_SIZE){w_data[DATA_SIZE-1]}}, w_data} <<< SHIFT;
    assign total    = acc + bias_ext;
    assign shifted  = total >>> SHIFT;

    always_comb begin
        score = '0;
        if (total[ACC_W-1])
            score = '0;
        else if (|shifted[ACC_W-1:DATA_SIZE])
            score = '1;
        else
            score = shifted[DATA_SIZE-1:0];
    end

    assign fc_busy = (state == LOAD) || (state == MAC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            nrn         <= '0;
            feat_q      <= '0;
            acc         <= '0;
            in_rdy      <= 1'b0;
            w_rd        <= 1'b0;
            w_addr      <= '0;
            fc_result   <= '0;
            classify_en <= 1'b0;
            for (int i = 0; i < N_IN; i++)
                fbuf[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (fc_start) begin
                        state       <= LOAD;
                        cnt         <= '0;
                        in_rdy      <= 1'b1;
                        w_addr      <= '0;
                        fc_result   <= '0;
                        classify_en <= 1'b0;
                    end else if (state == DONE) begin
                        classify_en <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_vld && in_rdy) begin
                        fbuf[cnt[IW-1:0]] <= in_data;
                        if (cnt == K_LAST) begin
                            state  <= MAC;
                            cnt    <= '0;
                            nrn    <= '0;
                            acc    <= '0;
                            in_rdy <= 1'b0;
                            w_rd   <= 1'b1;
                            w_addr <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                MAC: begin
                    if (cnt < K_BIAS)
                        feat_q <= fbuf[cnt[IW-1:0]];
                    if (cnt == K_WB) begin
                        // bias arrives now: fold it in and write the score
                        for (int i = 0; i < 10; i++)
                            if (nrn == 4'(i))
                                fc_result[(9-i)*DATA_SIZE +: DATA_SIZE] <= score;
                        acc <= '0;
                        cnt <= '0;
                        if (nrn == 4'd9) begin
                            state <= DONE;
                        end else begin
                            nrn    <= nrn + 4'd1;
                            w_rd   <= 1'b1;
                            w_addr <= w_addr + W_ADDR_W'(1);
                        end
                    end else begin
                        if (cnt != '0)
                            acc <= acc + prod_ext;
                        cnt <= cnt + CW'(1);
                        if (cnt < K_BIAS) begin
                            w_rd   <= 1'b1;
                            w_addr <= w_addr + W_ADDR_W'(1);
                        end else begin
                            w_rd <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_output_layer.sv
// Bench for fc_output_layer: two instances (SHIFT=0 and SHIFT=7) share one
// ROM image and stimulus; results checked against tables and a score model.
module tb_fc_output_layer;

    localparam int D  = 8;
    localparam int NI = 4;
    localparam int NW = 10 * (NI + 1);
    localparam int LAT = 10 * (NI + 2) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fc_start = 1'b0;
    logic        in_vld = 1'b0;
    logic [7:0]  in_data = '0;

    logic        in_rdy0, w_rd0, busy0, ce0;
    logic [9:0]  w_addr0;
    logic [7:0]  w_data0 = '0;
    logic [79:0] res0;

    logic        in_rdy7, w_rd7, busy7, ce7;
    logic [9:0]  w_addr7;
    logic [7:0]  w_data7 = '0;
    logic [79:0] res7;

    logic [7:0]  rom [NW];

    always #5 clk = ~clk;

    fc_output_layer #(.DATA_SIZE(D), .N_IN(NI), .ACC_W(24), .SHIFT(0), .W_ADDR_W(10)) dut0 (
        .clk(clk), .rst(rst), .fc_start(fc_start), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy0), .w_rd(w_rd0), .w_addr(w_addr0), .w_data(w_data0),
        .fc_busy(busy0), .fc_result(res0), .classify_en(ce0));

    fc_output_layer #(.DATA_SIZE(D), .N_IN(NI), .ACC_W(24), .SHIFT(7), .W_ADDR_W(10)) dut7 (
        .clk(clk), .rst(rst), .fc_start(fc_start), .in_vld(in_vld), .in_data(in_data),
        .in_rdy(in_rdy7), .w_rd(w_rd7), .w_addr(w_addr7), .w_data(w_data7),
        .fc_busy(busy7), .fc_result(res7), .classify_en(ce7));

    // ROM returns garbage when not read, which the DUT must ignore
    always @(posedge clk) begin
        w_data0 <= w_rd0 ? rom[w_addr0[5:0]] : 8'($urandom);
        w_data7 <= w_rd7 ? rom[w_addr7[5:0]] : 8'($urandom);
    end

    int rd_addr_q[$];
    always @(negedge clk)
        if (w_rd0) rd_addr_q.push_back(int'(w_addr0));

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int model_score(input int sh, input int n, input logic [3:0][7:0] f);
        longint acc = 0;
        byte sb;
        for (int k = 0; k < NI; k++) begin
            sb = rom[n*(NI+1)+k];
            acc += longint'(f[k]) * longint'(sb);
        end
        sb = rom[n*(NI+1)+NI];
        acc += longint'(sb) * (longint'(1) << sh);
        if (acc < 0) return 0;
        acc = acc >> sh;
        return (acc > 255) ? 255 : int'(acc);
    endfunction

    function automatic logic [79:0] model_res(input int sh, input logic [3:0][7:0] f);
        logic [79:0] r = '0;
        for (int n = 0; n < 10; n++)
            r[(9-n)*8 +: 8] = 8'(model_score(sh, n, f));
        return r;
    endfunction

    typedef struct packed {
        bit               sh7;
        logic [3:0][7:0]  feat;
        logic [9:0][7:0]  w;
        logic [9:0][7:0]  b;
        logic [9:0][7:0]  expv;
        int               maxgap;
        bit               poke;
    } vec_t;

    vec_t vt [4];

    task automatic load_rom(input vec_t v);
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < NI; k++) rom[n*(NI+1)+k] = v.w[n];
            rom[n*(NI+1)+NI] = v.b[n];
        end
    endtask

    function automatic logic [79:0] table_res(input vec_t v);
        logic [79:0] r = '0;
        for (int n = 0; n < 10; n++) r[(9-n)*8 +: 8] = v.expv[n];
        return r;
    endfunction

    task automatic run_image(input logic [3:0][7:0] f, input int maxgap,
                             input bit poke, input int stop_at);
        int lat;
        bit ok;
        rd_addr_q.delete();
        @(negedge clk); fc_start = 1'b1;
        @(negedge clk); fc_start = 1'b0;
        chk("load_in_rdy", {in_rdy0, in_rdy7, busy0}, 3'b111);
        for (int i = 0; i < NI; i++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            in_vld = 1'b1; in_data = f[i];
            @(negedge clk);
            in_vld = 1'b0; in_data = 8'($urandom);
        end
        lat = 0;
        while (!ce0 && lat < 200) begin
            if (stop_at > 0 && lat == stop_at) return;
            if (poke && lat == 20) fc_start = 1'b1;
            @(negedge clk);
            fc_start = 1'b0;
            lat++;
        end
        chk("latency", 128'(lat), 128'(LAT));
        chk("ce7_sync", {ce7, ce0}, 2'b11);
        chk("rd_count", 128'(rd_addr_q.size()), 128'(NW));
        ok = (rd_addr_q.size() == NW);
        for (int i = 0; i < rd_addr_q.size(); i++)
            if (rd_addr_q[i] != i) ok = 1'b0;
        chk("rd_addr_order", ok, 1'b1);
        chk("res_shift0", res0, model_res(0, f));
        chk("res_shift7", res7, model_res(7, f));
        chk("done_idle_outs", {busy0, busy7, in_rdy0, w_rd0}, 4'b0);
        repeat (6) @(negedge clk);
        chk("hold_res", {res0, ce0}, {model_res(0, f), 1'b1});
    endtask

    initial begin
        logic [3:0][7:0] f;

        for (int i = 0; i < 4; i++) vt[i] = '0;
        for (int k = 0; k < NI; k++) vt[0].feat[k] = 8'(k + 1);
        vt[0].w[3] = 8'd1;  vt[0].expv[3] = 8'd10;
        for (int k = 0; k < NI; k++) vt[1].feat[k] = 8'd255;
        vt[1].w[0] = 8'd127; vt[1].expv[0] = 8'd255;
        vt[1].w[1] = 8'hFF;  vt[1].expv[1] = 8'd0;
        vt[2].sh7 = 1'b1;
        for (int k = 0; k < NI; k++) vt[2].feat[k] = 8'd128;
        vt[2].w[9] = 8'd32; vt[2].expv[9] = 8'd128;
        vt[2].w[8] = 8'd32; vt[2].b[8] = 8'hFF; vt[2].expv[8] = 8'd127;
        vt[3] = vt[0]; vt[3].maxgap = 3; vt[3].poke = 1'b1;
        for (int i = 0; i < NW; i++) rom[i] = '0;

        repeat (5) begin
            @(negedge clk);
            fc_start = 1'($urandom); in_vld = 1'($urandom); in_data = 8'($urandom);
        end
        chk("reset_outs0", {in_rdy0, w_rd0, w_addr0, busy0, res0, ce0}, '0);
        chk("reset_outs7", {in_rdy7, w_rd7, w_addr7, busy7, res7, ce7}, '0);
        @(negedge clk); rst = 1'b1; fc_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            in_vld = 1'($urandom); in_data = 8'($urandom);
        end
        chk("idle_wait", {in_rdy0, busy0, ce0, res0}, '0);
        in_vld = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_rom(vt[v]);
            run_image(vt[v].feat, vt[v].maxgap, vt[v].poke, 0);
            chk($sformatf("table_%0d", v), vt[v].sh7 ? res7 : res0, table_res(vt[v]));
        end

        @(negedge clk); fc_start = 1'b1;
        @(negedge clk); fc_start = 1'b0;
        chk("restart_from_done", {ce0, res0, in_rdy0}, {1'b0, 80'b0, 1'b1});
        run_image(vt[0].feat, 1, 1'b0, 0);
        chk("restart_table", res0, table_res(vt[0]));

        run_image(vt[1].feat, 0, 1'b0, 32);
        rst = 1'b0;
        #1;
        chk("midmac_reset0", {in_rdy0, w_rd0, w_addr0, busy0, res0, ce0}, '0);
        chk("midmac_reset7", {in_rdy7, w_rd7, w_addr7, busy7, res7, ce7}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        load_rom(vt[0]);
        run_image(vt[0].feat, 0, 1'b0, 0);
        chk("post_reset_table", res0, table_res(vt[0]));

        repeat (8) begin
            for (int i = 0; i < NW; i++) rom[i] = 8'($urandom);
            for (int k = 0; k < NI; k++) f[k] = 8'($urandom);
            run_image(f, $urandom_range(2, 0), 1'($urandom), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
